pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Consumes the EX-stage redirect (jump or taken branch plus target), the ID/EX load-use operands, the instruction-memory ready signal and the data-memory busy signal.
- Drives the PC load/select and the per-stage register write-enables and flushes.
- Holds a redirect pending across instruction-memory wait states and keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: resolves EX redirects,
// load-use hazards and memory wait states into PC and pipeline-register
// controls, and keeps saturating stall/flush counters for performance debug.
module pipe_hazard_ctrl #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_ex,
   input  logic [XLEN-1:0]       redirect_pc,
   input  logic                  mem_read_ex,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   input  logic                  imem_ready,
   input  logic                  dmem_busy,
   output logic                  pc_we,
   output logic                  pc_sel,
   output logic [XLEN-1:0]       pc_target,
   output logic                  if_id_we,
   output logic                  if_id_flush,
   output logic                  id_ex_we,
   output logic                  id_ex_flush,
   output logic                  ex_mem_we,
   output logic                  mem_wb_we,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   typedef enum logic {
      RUN        = 1'b0,
      REDIR_WAIT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [XLEN-1:0]  pending, pending_nxt;
   logic             stall_inc, flush_inc;
   logic             lu;

   // Load-use hazard: ID reads a register the EX-stage load has not yet produced
   always_comb begin
      lu = mem_read_ex && (rd_ex != '0) &&
           ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));
   end

   // Next-state and control decode; defaults describe a normally advancing pipe
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      pc_we       = 1'b1;
      pc_sel      = 1'b0;
      pc_target   = redirect_pc;
      if_id_we    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_we    = 1'b1;
      id_ex_flush = 1'b0;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;

      if (rst) begin
         state_nxt   = RUN;
         pending_nxt = '0;
         pc_we       = 1'b0;
         pc_target   = '0;
         if_id_we    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_we    = 1'b0;
         id_ex_flush = 1'b1;
         ex_mem_we   = 1'b0;
         mem_wb_we   = 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (dmem_busy) begin
                  pc_we     = 1'b0;
                  if_id_we  = 1'b0;
                  id_ex_we  = 1'b0;
                  ex_mem_we = 1'b0;
                  mem_wb_we = 1'b0;
                  stall_inc = 1'b1;
               end else if (redirect_ex) begin
                  pc_sel      = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  flush_inc   = 1'b1;
                  if (!imem_ready) begin
                     pc_we       = 1'b0;
                     pending_nxt = redirect_pc;
                     stall_inc   = 1'b1;
                     state_nxt   = REDIR_WAIT;
                  end
               end else if (lu) begin
                  pc_we       = 1'b0;
                  if_id_we    = 1'b0;
                  id_ex_flush = 1'b1;
                  stall_inc   = 1'b1;
               end else if (!imem_ready) begin
                  pc_we       = 1'b0;
                  if_id_flush = 1'b1;
                  stall_inc   = 1'b1;
               end
            end
            REDIR_WAIT: begin
               pc_sel    = 1'b1;
               pc_target = pending;
               if (dmem_busy) begin
                  pc_we     = 1'b0;
                  if_id_we  = 1'b0;
                  id_ex_we  = 1'b0;
                  ex_mem_we = 1'b0;
                  mem_wb_we = 1'b0;
                  stall_inc = 1'b1;
               end else begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  if (imem_ready) begin
                     state_nxt = RUN;
                  end else begin
                     pc_we     = 1'b0;
                     stall_inc = 1'b1;
                  end
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // State, pending target and saturating counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         pending   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a rule-level model.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_ex;
   logic [31:0] redirect_pc;
   logic        mem_read_ex;
   logic [4:0]  rd_ex, rs1_id, rs2_id;
   logic        rs1_used, rs2_used;
   logic        imem_ready, dmem_busy;

   logic        pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we;
   logic [31:0] pc_target;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_we, s_pc_sel, s_if_id_we, s_if_id_flush, s_id_ex_we, s_id_ex_flush;
   logic        s_ex_mem_we, s_mem_wb_we;
   logic [31:0] s_pc_target;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int errors = 0;
   int checks = 0;

   // model state
   bit          m_wait;
   logic [31:0] m_pend;
   int          m_stalls, m_flushes;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .redirect_ex(redirect_ex), .redirect_pc(redirect_pc),
      .mem_read_ex(mem_read_ex), .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
      .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target), .if_id_we(if_id_we),
      .if_id_flush(if_id_flush), .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
      .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .redirect_ex(redirect_ex), .redirect_pc(redirect_pc),
      .mem_read_ex(mem_read_ex), .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
      .pc_we(s_pc_we), .pc_sel(s_pc_sel), .pc_target(s_pc_target), .if_id_we(s_if_id_we),
      .if_id_flush(s_if_id_flush), .id_ex_we(s_id_ex_we), .id_ex_flush(s_id_ex_flush),
      .ex_mem_we(s_ex_mem_we), .mem_wb_we(s_mem_wb_we), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit load_use();
      return mem_read_ex && (rd_ex != 0) &&
             ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // Compare outputs against the rule table for the present model state and inputs
   task automatic compare_outputs();
      bit e_pcwe = 1, e_sel = 0, e_ifwe = 1, e_iffl = 0, e_idwe = 1, e_idfl = 0, e_exwe = 1, e_wbwe = 1;
      logic [31:0] e_tgt = 32'h0;
      bit freeze = 0;
      if (rst) begin
         {e_pcwe, e_ifwe, e_idwe, e_exwe, e_wbwe} = '0;
         e_iffl = 1; e_idfl = 1;
      end else if (m_wait) begin
         e_sel = 1; e_tgt = m_pend;
         if (dmem_busy) freeze = 1;
         else begin e_iffl = 1; e_idfl = 1; e_pcwe = imem_ready; end
      end else if (dmem_busy) begin
         freeze = 1;
      end else if (redirect_ex) begin
         e_sel = 1; e_tgt = redirect_pc; e_iffl = 1; e_idfl = 1; e_pcwe = imem_ready;
      end else if (load_use()) begin
         e_pcwe = 0; e_ifwe = 0; e_idfl = 1;
      end else if (!imem_ready) begin
         e_pcwe = 0; e_iffl = 1;
      end
      if (freeze) {e_pcwe, e_ifwe, e_idwe, e_exwe, e_wbwe} = '0;
      check("ctrl", {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we},
            {e_pcwe, e_sel, e_ifwe, e_iffl, e_idwe, e_idfl, e_exwe, e_wbwe});
      if (e_sel || rst) check("pc_target", pc_target, e_tgt);
      check("stall_cnt", stall_cnt, sat(m_stalls, 65535));
      check("flush_cnt", flush_cnt, sat(m_flushes, 65535));
      check("stall_cnt4", s_stall_cnt, sat(m_stalls, 15));
      check("flush_cnt4", s_flush_cnt, sat(m_flushes, 15));
   endtask

   // Advance the model by one clock according to the sequencing rules
   task automatic model_clock();
      if (rst) begin
         m_wait = 0; m_pend = 0; m_stalls = 0; m_flushes = 0;
      end else if (m_wait) begin
         if (dmem_busy || !imem_ready) m_stalls++;
         else m_wait = 0;
      end else if (dmem_busy) begin
         m_stalls++;
      end else if (redirect_ex) begin
         m_flushes++;
         if (!imem_ready) begin m_stalls++; m_wait = 1; m_pend = redirect_pc; end
      end else if (load_use() || !imem_ready) begin
         m_stalls++;
      end
   endtask

   task automatic idle();
      rst = 0; redirect_ex = 0; redirect_pc = 32'h0; mem_read_ex = 0;
      rd_ex = 0; rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
      imem_ready = 1; dmem_busy = 0;
   endtask

   // Inputs already applied: sample mid-cycle, then cross the edge
   task automatic step();
      #4;
      compare_outputs();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   initial begin
      m_wait = 0; m_pend = 0; m_stalls = 0; m_flushes = 0;
      idle();
      rst = 1;
      @(posedge clk); #1;
      step(); step();
      idle();
      #4;
      check("reset_stall", stall_cnt, 16'd0);
      check("reset_flush", flush_cnt, 16'd0);
      #6;

      // redirect taken with fetch ready
      redirect_ex = 1; redirect_pc = 32'h100; step();
      idle(); step();

      // redirect while fetch stalls three cycles
      redirect_ex = 1; redirect_pc = 32'h40; imem_ready = 0; step();
      idle(); imem_ready = 0; step(); step();
      imem_ready = 1; step();
      idle(); step();

      // load-use via rs2, then same with x0 destination
      mem_read_ex = 1; rd_ex = 5; rs2_id = 5; rs2_used = 1; step();
      idle(); step();
      mem_read_ex = 1; rd_ex = 0; rs2_id = 0; rs2_used = 1; step();
      idle();

      // freeze beats a redirect and a load-use, then redirect wins
      dmem_busy = 1; redirect_ex = 1; redirect_pc = 32'h300;
      mem_read_ex = 1; rd_ex = 7; rs1_id = 7; rs1_used = 1; step(); step();
      dmem_busy = 0; step();
      idle(); step();

      // reset while a redirect is pending
      redirect_ex = 1; redirect_pc = 32'h200; imem_ready = 0; step();
      idle(); imem_ready = 0; step();
      rst = 1; step();
      idle(); step();

      // counter saturation on the 4-bit instance
      dmem_busy = 1;
      for (int i = 0; i < 20; i++) step();
      idle();
      #4;
      check("sat_hold", s_stall_cnt, 4'hf);
      #6;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         redirect_ex = ($urandom_range(0, 7) == 0);
         redirect_pc = $urandom;
         mem_read_ex = $urandom_range(0, 1);
         rd_ex       = 5'($urandom_range(0, 3));
         rs1_id      = 5'($urandom_range(0, 3));
         rs2_id      = 5'($urandom_range(0, 3));
         rs1_used    = $urandom_range(0, 1);
         rs2_used    = $urandom_range(0, 1);
         imem_ready  = ($urandom_range(0, 3) != 0);
         dmem_busy   = ($urandom_range(0, 5) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
